blackjack_round_ctrl: RTL and testbench

Round sequencer for the blackjack game; sits directly downstream of the button debouncers. Turns the debounced deal/hit/stand levels into single-cycle actions, requests cards from the deck block over a req/ack handshake, tracks player and dealer hand totals with ace handling, and declares the round result.

---
 rtl/blackjack_round_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_blackjack_round_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: button edge detection, card req/ack handshake with the deck,
// soft/hard hand totals and round resolution.
module blackjack_round_ctrl (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       deal_btn,
  input  logic       hit_btn,
  input  logic       stand_btn,
  output logic       card_req,
  input  logic       card_ack,
  input  logic [3:0] card_value,
  output logic       card_to_dealer,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic       dealer_hidden,
  output logic [1:0] result,
  output logic       round_done
);

  typedef enum logic [3:0] {
    StIdle, StDealP1, StDealD1, StDealP2, StDealD2, StCheckNat,
    StPlayerTurn, StPlayerDraw, StDealerDraw, StResolve, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [4:0]  p_hard_q, p_hard_d, d_hard_q, d_hard_d;
  logic        p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic        p_nat_q, p_nat_d, d_nat_q, d_nat_d;
  logic        hidden_q, hidden_d;
  logic [1:0]  result_q, result_d;

  // Buttons packed as {deal, hit, stand}
  logic [2:0]  btn_meta_q, btn_sync_q, btn_prev_q, btn_pulse;
  logic        deal_pulse, hit_pulse, stand_pulse;

  logic [4:0]  card_pts;
  logic        card_is_ace;
  logic [4:0]  p_eff, d_eff, p_eff_new;

  function automatic logic [4:0] eff_total(input logic [4:0] hard, input logic ace);
    return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
  endfunction

  assign btn_pulse   = btn_sync_q & ~btn_prev_q;
  assign deal_pulse  = btn_pulse[2];
  assign hit_pulse   = btn_pulse[1];
  assign stand_pulse = btn_pulse[0];

  assign card_pts    = (card_value == 4'd0 || card_value > 4'd10) ? 5'd10 : {1'b0, card_value};
  assign card_is_ace = (card_pts == 5'd1);
  assign p_eff       = eff_total(p_hard_q, p_ace_q);
  assign d_eff       = eff_total(d_hard_q, d_ace_q);
  assign p_eff_new   = eff_total(p_hard_q + card_pts, p_ace_q | card_is_ace);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      p_hard_q   <= '0;
      d_hard_q   <= '0;
      p_ace_q    <= 1'b0;
      d_ace_q    <= 1'b0;
      p_nat_q    <= 1'b0;
      d_nat_q    <= 1'b0;
      hidden_q   <= 1'b0;
      result_q   <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      p_hard_q   <= p_hard_d;
      d_hard_q   <= d_hard_d;
      p_ace_q    <= p_ace_d;
      d_ace_q    <= d_ace_d;
      p_nat_q    <= p_nat_d;
      d_nat_q    <= d_nat_d;
      hidden_q   <= hidden_d;
      result_q   <= result_d;
      btn_meta_q <= {deal_btn, hit_btn, stand_btn};
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = 1'b0;
    p_hard_d = p_hard_q;
    d_hard_d = d_hard_q;
    p_ace_d  = p_ace_q;
    d_ace_d  = d_ace_q;
    p_nat_d  = p_nat_q;
    d_nat_d  = d_nat_q;
    hidden_d = hidden_q;
    result_d = result_q;
    case (state_q)
      StIdle, StDone: begin
        if (deal_pulse) begin
          p_hard_d = '0;
          d_hard_d = '0;
          p_ace_d  = 1'b0;
          d_ace_d  = 1'b0;
          p_nat_d  = 1'b0;
          d_nat_d  = 1'b0;
          result_d = '0;
          hidden_d = 1'b1;
          req_d    = 1'b1;
          state_d  = StDealP1;
        end
      end
      StDealP1, StDealD1, StDealP2, StDealD2, StPlayerDraw: begin
        // Request drops for one cycle after every accepted card
        if (!(req_q && card_ack)) begin
          req_d = 1'b1;
        end else begin
          if (card_to_dealer) begin
            d_hard_d = d_hard_q + card_pts;
            d_ace_d  = d_ace_q | card_is_ace;
          end else begin
            p_hard_d = p_hard_q + card_pts;
            p_ace_d  = p_ace_q | card_is_ace;
          end
          case (state_q)
            StDealP1: state_d = StDealD1;
            StDealD1: state_d = StDealP2;
            StDealP2: state_d = StDealD2;
            StDealD2: state_d = StCheckNat;
            default: begin
              if (p_eff_new > 5'd21) begin
                hidden_d = 1'b0;
                state_d  = StResolve;
              end else if (p_eff_new == 5'd21) begin
                hidden_d = 1'b0;
                state_d  = StDealerDraw;
              end else begin
                state_d  = StPlayerTurn;
              end
            end
          endcase
        end
      end
      StCheckNat: begin
        p_nat_d = (p_eff == 5'd21);
        d_nat_d = (d_eff == 5'd21);
        if (p_eff == 5'd21 || d_eff == 5'd21) begin
          hidden_d = 1'b0;
          state_d  = StResolve;
        end else begin
          state_d  = StPlayerTurn;
        end
      end
      StPlayerTurn: begin
        if (stand_pulse) begin
          hidden_d = 1'b0;
          state_d  = StDealerDraw;
        end else if (hit_pulse) begin
          req_d   = 1'b1;
          state_d = StPlayerDraw;
        end
      end
      StDealerDraw: begin
        // With req low the totals are current, so that cycle decides draw vs. stand
        if (req_q) begin
          if (card_ack) begin
            d_hard_d = d_hard_q + card_pts;
            d_ace_d  = d_ace_q | card_is_ace;
          end else begin
            req_d = 1'b1;
          end
        end else if (d_eff >= 5'd17) begin
          state_d = StResolve;
        end else begin
          req_d = 1'b1;
        end
      end
      StResolve: begin
        if (p_eff > 5'd21)            result_d = 2'd2;
        else if (d_eff > 5'd21)       result_d = 2'd1;
        else if (p_nat_q && !d_nat_q) result_d = 2'd1;
        else if (d_nat_q && !p_nat_q) result_d = 2'd2;
        else if (p_eff > d_eff)       result_d = 2'd1;
        else if (p_eff < d_eff)       result_d = 2'd2;
        else                          result_d = 2'd3;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    card_req       = req_q;
    card_to_dealer = (state_q == StDealD1) || (state_q == StDealD2) ||
                     (state_q == StDealerDraw);
    player_total   = p_eff;
    dealer_total   = d_eff;
    dealer_hidden  = hidden_q;
    result         = result_q;
    round_done     = (state_q == StDone);
  end

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Randomized scoreboard bench for blackjack_round_ctrl with a card-list reference model.
module tb_blackjack_round_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       deal_btn, hit_btn, stand_btn;
  logic       card_req, card_ack;
  logic [3:0] card_value;
  logic       card_to_dealer;
  logic [4:0] player_total, dealer_total;
  logic       dealer_hidden;
  logic [1:0] result;
  logic       round_done;

  always #5 CLOCK_50 = ~CLOCK_50;

  blackjack_round_ctrl dut (
    .CLOCK_50       (CLOCK_50),
    .resetn         (resetn),
    .deal_btn       (deal_btn),
    .hit_btn        (hit_btn),
    .stand_btn      (stand_btn),
    .card_req       (card_req),
    .card_ack       (card_ack),
    .card_value     (card_value),
    .card_to_dealer (card_to_dealer),
    .player_total   (player_total),
    .dealer_total   (dealer_total),
    .dealer_hidden  (dealer_hidden),
    .result         (result),
    .round_done     (round_done)
  );

  typedef struct {
    int res;
    int pt;
    int dt;
  } exp_t;

  exp_t sb[$];
  int   deck[$];
  int   served;
  bit   hold_deck;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Deck responder: random ack latency, plus stray acks while no request is pending.
  initial begin
    int delay = 0;
    card_ack   = 1'b0;
    card_value = 4'd0;
    forever begin
      @(negedge CLOCK_50);
      if (card_ack) begin
        card_ack = 1'b0;
      end else if (card_req && !hold_deck) begin
        if (delay > 0) begin
          delay--;
        end else begin
          card_ack = 1'b1;
          if (deck.size() == 0) begin
            check("deck_underflow", 1, 0);
            card_value = 4'd10;
          end else begin
            card_value = 4'(deck.pop_front());
          end
          served++;
          delay = $urandom_range(0, 3);
        end
      end else if (!card_req && !hold_deck && $urandom_range(0, 9) == 0) begin
        card_ack   = 1'b1;
        card_value = 4'($urandom_range(0, 15));
      end
    end
  end

  // Monitor: compare each completed round against the oldest expectation.
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (resetn && round_done && !prev) begin
        if (sb.size() == 0) begin
          check("unexpected_round_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", int'(result), e.res);
          check("player_total", int'(player_total), e.pt);
          check("dealer_total", int'(dealer_total), e.dt);
          check("hidden_at_done", int'(dealer_hidden), 0);
        end
      end
      prev = round_done;
    end
  end

  function automatic int norm(input int raw);
    return (raw == 0 || raw > 10) ? 10 : raw;
  endfunction

  function automatic int hval(input int cards[$]);
    int s = 0;
    bit ace = 0;
    foreach (cards[i]) begin
      s += cards[i];
      if (cards[i] == 1) ace = 1;
    end
    return (ace && s + 10 <= 21) ? s + 10 : s;
  endfunction

  // Plays the round from the card list: player hits while below limit, dealer to 17.
  task automatic model(input int raw[48], input int limit, output exp_t e, output int ncards,
                       output int nhits, output bit stand_press, output bit natural);
    int p[$];
    int d[$];
    int idx;
    int pt, dt;
    p.push_back(norm(raw[0]));
    d.push_back(norm(raw[1]));
    p.push_back(norm(raw[2]));
    d.push_back(norm(raw[3]));
    idx = 4;
    nhits = 0;
    stand_press = 0;
    pt = hval(p);
    dt = hval(d);
    natural = (pt == 21 || dt == 21);
    if (natural) begin
      e.res = (pt == dt) ? 3 : (pt == 21) ? 1 : 2;
    end else begin
      while (pt < limit) begin
        p.push_back(norm(raw[idx]));
        idx++;
        nhits++;
        pt = hval(p);
      end
      if (pt > 21) begin
        e.res = 2;
      end else begin
        stand_press = (pt < 21);
        while (dt < 17) begin
          d.push_back(norm(raw[idx]));
          idx++;
          dt = hval(d);
        end
        e.res = (dt > 21) ? 1 : (pt > dt) ? 1 : (pt < dt) ? 2 : 3;
      end
    end
    e.pt = pt;
    e.dt = dt;
    ncards = idx;
  endtask

  task automatic press(input bit d, input bit h, input bit s, input int hold);
    @(negedge CLOCK_50);
    deal_btn  = d;
    hit_btn   = h;
    stand_btn = s;
    repeat (hold) @(negedge CLOCK_50);
    deal_btn  = 1'b0;
    hit_btn   = 1'b0;
    stand_btn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic wait_served(input int n);
    int k = 0;
    while (served < n && k < 500) begin
      @(negedge CLOCK_50);
      k++;
    end
    if (served < n) check("card_wait_timeout", served, n);
  endtask

  task automatic run_round(input int raw[48], input int limit, input int hit_hold,
                           input bit combo);
    exp_t e;
    int   ncards, nhits, k;
    bit   stand_press, natural;
    model(raw, limit, e, ncards, nhits, stand_press, natural);
    sb.push_back(e);
    deck.delete();
    for (int i = 0; i < ncards; i++) deck.push_back(raw[i]);
    served = 0;
    press(1'b1, 1'b0, 1'b0, $urandom_range(1, 10));
    if (!natural) begin
      for (int i = 0; i < nhits; i++) begin
        wait_served(4 + i);
        repeat (4) @(negedge CLOCK_50);
        check("hidden_in_turn", int'(dealer_hidden), 1);
        press(1'b0, 1'b1, 1'b0, hit_hold);
      end
      if (stand_press) begin
        wait_served(4 + nhits);
        repeat (4) @(negedge CLOCK_50);
        press(1'b0, combo, 1'b1, $urandom_range(1, 5));
      end
    end
    k = 0;
    while (!round_done && k < 4000) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("round_done_reached", int'(round_done), 1);
    repeat (3) @(negedge CLOCK_50);
    check("deck_cards_left", deck.size(), 0);
  endtask

  initial begin
    int raw[48];
    int k;
    resetn    = 1'b0;
    deal_btn  = 1'b0;
    hit_btn   = 1'b0;
    stand_btn = 1'b0;
    hold_deck = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    check("rst_card_req", int'(card_req), 0);
    check("rst_to_dealer", int'(card_to_dealer), 0);
    check("rst_player_total", int'(player_total), 0);
    check("rst_dealer_total", int'(dealer_total), 0);
    check("rst_hidden", int'(dealer_hidden), 0);
    check("rst_result", int'(result), 0);
    check("rst_round_done", int'(round_done), 0);
    resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Reset while a card request is outstanding
    press(1'b1, 1'b0, 1'b0, 2);
    k = 0;
    while (!card_req && k < 20) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("req_before_reset", int'(card_req), 1);
    check("hidden_after_deal", int'(dealer_hidden), 1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_card_req", int'(card_req), 0);
    check("async_rst_hidden", int'(dealer_hidden), 0);
    check("async_rst_player_total", int'(player_total), 0);
    check("async_rst_round_done", int'(round_done), 0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    hold_deck = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("idle_after_reset_req", int'(card_req), 0);

    // Directed rounds
    raw = '{default: 0};
    raw[0:4] = '{10, 7, 9, 8, 5};
    run_round(raw, 0, 2, 1'b0);
    raw = '{default: 0};
    raw[0:3] = '{1, 10, 10, 6};
    run_round(raw, 0, 2, 1'b0);
    raw = '{default: 0};
    raw[0:4] = '{10, 10, 6, 6, 9};
    run_round(raw, 17, 3, 1'b0);
    raw = '{default: 0};
    raw[0:3] = '{10, 1, 7, 6};
    run_round(raw, 0, 2, 1'b0);
    raw = '{default: 0};
    raw[0:5] = '{10, 5, 3, 10, 3, 4};
    run_round(raw, 14, 500, 1'b1);

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 48; i++) raw[i] = $urandom_range(0, 15);
      run_round(raw, $urandom_range(0, 20),
                ($urandom_range(0, 7) == 0) ? 500 : $urandom_range(1, 20),
                $urandom_range(0, 3) == 0);
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
